// File: rtl/ghost_mode_scheduler_pkg.sv
// Shared encodings for the ghost scheduler and the per-ghost controllers:
// game-state codes, global mode codes, the scatter/chase schedule and FSM states.
package ghost_mode_scheduler_pkg;

  localparam logic [7:0] GS_IDLE     = 8'h00;
  localparam logic [7:0] GS_PLAY     = 8'h01;
  localparam logic [7:0] GS_PAUSE    = 8'h02;
  localparam logic [7:0] GS_RELOAD   = 8'h03;
  localparam logic [7:0] GS_CLEAR    = 8'h04;
  localparam logic [7:0] GS_GAMEOVER = 8'h05;

  localparam logic [3:0] SCATTER    = 4'd1;
  localparam logic [3:0] CHASE      = 4'd2;
  localparam logic [3:0] FRIGHTENED = 4'd3;

  localparam int NUM_PHASES     = 8;
  localparam logic [2:0] LAST_PHASE = 3'd7;
  // Phase lengths in seconds; 0 marks the final phase that never ends.
  localparam int PHASE_SECS [NUM_PHASES] = '{7, 20, 7, 20, 5, 20, 5, 0};
  localparam int MAX_PHASE_SECS = 20;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FRIGHT = 2'd2,
    ST_FROZEN = 2'd3
  } sched_state_t;

  // Even phases scatter, odd phases chase.
  function automatic logic [3:0] phase_mode(input logic [2:0] phase);
    return phase[0] ? CHASE : SCATTER;
  endfunction

endpackage

// File: rtl/ghost_mode_scheduler_if.sv
// Bundle between the game FSM side (master) and the ghost scheduler (slave).
interface ghost_mode_scheduler_if #(
  parameter int NUM_GHOSTS = 4
);
  import ghost_mode_scheduler_pkg::*;

  logic [7:0]            game_state;
  logic                  tick;
  logic                  power_pellet;
  logic [3:0]            ghost_state;
  logic [NUM_GHOSTS-1:0] ghost_reload;
  logic                  reverse;
  logic                  fright_flash;
  logic [2:0]            phase;

  modport master (
    output game_state, tick, power_pellet,
    input  ghost_state, ghost_reload, reverse, fright_flash, phase
  );

  modport slave (
    input  game_state, tick, power_pellet,
    output ghost_state, ghost_reload, reverse, fright_flash, phase
  );

endinterface

// File: rtl/ghost_mode_scheduler_release_seq.sv
// Staggered ghost release: counts play ticks and pulses one reload per ghost,
// lowest index first, once the tick count reaches that ghost's slot.
module ghost_release_seq
  import ghost_mode_scheduler_pkg::*;
#(
  parameter int NUM_GHOSTS  = 4,
  parameter int RELEASE_GAP = 240
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  tick,
  output logic [NUM_GHOSTS-1:0] reload
);

  localparam int RC_MAX = (NUM_GHOSTS - 1) * RELEASE_GAP;
  localparam int RC_W   = $clog2(RC_MAX) + 1;
  localparam logic [RC_W-1:0] RC_ONE = RC_W'(1);

  logic [RC_W-1:0]       release_cnt;
  logic [NUM_GHOSTS-1:0] released;
  logic [NUM_GHOSTS-1:0] pick;
  logic                  found;
  logic                  all_released;

  // Select the lowest-index ghost that is due and not yet out.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_GHOSTS; k++) begin
      if (!found && !released[k] && (int'(release_cnt) >= k * RELEASE_GAP)) begin
        pick[k] = 1'b1;
        found   = 1'b1;
      end
    end
    all_released = &released;
  end

  // Tick counter, released mask and registered one-cycle reload pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      release_cnt <= '0;
      released    <= '0;
      reload      <= '0;
    end else if (clear) begin
      release_cnt <= '0;
      released    <= '0;
      reload      <= '0;
    end else begin
      reload <= enable ? pick : '0;
      if (enable) begin
        released <= released | pick;
      end
      if (tick && !all_released && (int'(release_cnt) < RC_MAX)) begin
        release_cnt <= release_cnt + RC_ONE;
      end
    end
  end

endmodule

// File: rtl/ghost_mode_scheduler.sv
// Global ghost mode sequencer: scatter/chase schedule, frightened override
// with end-of-fright flash, pause freeze, and staggered ghost release.
//
//   state     | meaning
//   ST_HOLD   | not playing; everything cleared, mode SCATTER
//   ST_RUN    | schedule advancing on ticks
//   ST_FRIGHT | frightened; schedule frozen, fright timer counting down
//   ST_FROZEN | paused; all state held, resumes RUN or FRIGHT on PLAY
module ghost_mode_scheduler
  import ghost_mode_scheduler_pkg::*;
#(
  parameter int NUM_GHOSTS    = 4,
  parameter int TICKS_PER_SEC = 60,
  parameter int FRIGHT_TICKS  = 360,
  parameter int FLASH_TICKS   = 120,
  parameter int RELEASE_GAP   = 240
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ghost_mode_scheduler_if.slave  bus
);

  localparam int PC_W = $clog2(MAX_PHASE_SECS * TICKS_PER_SEC) + 1;
  localparam int FC_W = $clog2(FRIGHT_TICKS) + 1;
  localparam logic [PC_W-1:0] PC_ONE      = PC_W'(1);
  localparam logic [FC_W-1:0] FC_ONE      = FC_W'(1);
  localparam logic [FC_W-1:0] FRIGHT_LOAD = FC_W'(FRIGHT_TICKS);
  localparam logic [FC_W-1:0] FLASH_LIM   = FC_W'(FLASH_TICKS);

  sched_state_t    state;
  sched_state_t    resume_state;
  logic [2:0]      phase;
  logic [PC_W-1:0] phase_cnt;
  logic [PC_W-1:0] phase_last;
  logic [FC_W-1:0] fright_cnt;
  logic [FC_W-1:0] fright_nxt;
  logic [3:0]      ghost_state;
  logic            reverse;
  logic            fright_flash;

  logic            in_play;
  logic            paused;
  logic            holding;
  logic            phase_end;
  logic            rel_enable;
  logic            rel_tick;

  // Decode the game state and the end-of-phase / fright-decrement conditions.
  always_comb begin
    in_play    = (bus.game_state == GS_PLAY);
    paused     = (bus.game_state == GS_PAUSE);
    holding    = !in_play && !paused;
    phase_last = PC_W'(PHASE_SECS[phase] * TICKS_PER_SEC - 1);
    phase_end  = (phase != LAST_PHASE) && (phase_cnt == phase_last);
    fright_nxt = fright_cnt - FC_ONE;
    // Release logic runs whenever play is live, including the HOLD->RUN cycle
    // so ghost 0 comes out together with the first RUN cycle.
    rel_enable = in_play && (state != ST_FROZEN);
    rel_tick   = bus.tick && in_play && ((state == ST_RUN) || (state == ST_FRIGHT));
  end

  // Scheduler FSM with registered mode, reverse and flash outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_HOLD;
      resume_state <= ST_RUN;
      phase        <= '0;
      phase_cnt    <= '0;
      fright_cnt   <= '0;
      ghost_state  <= SCATTER;
      reverse      <= 1'b0;
      fright_flash <= 1'b0;
    end else begin
      reverse <= 1'b0;
      if (holding) begin
        state        <= ST_HOLD;
        resume_state <= ST_RUN;
        phase        <= '0;
        phase_cnt    <= '0;
        fright_cnt   <= '0;
        ghost_state  <= SCATTER;
        fright_flash <= 1'b0;
      end else begin
        case (state)
          ST_HOLD: begin
            if (in_play) begin
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (paused) begin
              resume_state <= ST_RUN;
              state        <= ST_FROZEN;
            end else if (bus.power_pellet) begin
              state        <= ST_FRIGHT;
              fright_cnt   <= FRIGHT_LOAD;
              fright_flash <= (FRIGHT_LOAD <= FLASH_LIM);
              ghost_state  <= FRIGHTENED;
              reverse      <= 1'b1;
            end else if (bus.tick) begin
              if (phase_end) begin
                phase       <= phase + 3'd1;
                phase_cnt   <= '0;
                ghost_state <= phase_mode(phase + 3'd1);
                reverse     <= 1'b1;
              end else if (phase_cnt != '1) begin
                phase_cnt <= phase_cnt + PC_ONE;
              end
            end
          end
          ST_FRIGHT: begin
            if (paused) begin
              resume_state <= ST_FRIGHT;
              state        <= ST_FROZEN;
            end else if (bus.power_pellet) begin
              // Refresh only; the ghosts already reversed on entry.
              fright_cnt   <= FRIGHT_LOAD;
              fright_flash <= (FRIGHT_LOAD <= FLASH_LIM);
            end else if (bus.tick) begin
              if (fright_cnt == FC_ONE) begin
                state        <= ST_RUN;
                fright_cnt   <= '0;
                fright_flash <= 1'b0;
                ghost_state  <= phase_mode(phase);
              end else begin
                fright_cnt   <= fright_nxt;
                fright_flash <= (fright_nxt <= FLASH_LIM);
              end
            end
          end
          ST_FROZEN: begin
            if (in_play) begin
              state <= resume_state;
            end
          end
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

  ghost_release_seq #(
    .NUM_GHOSTS  (NUM_GHOSTS),
    .RELEASE_GAP (RELEASE_GAP)
  ) u_release (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (holding),
    .enable  (rel_enable),
    .tick    (rel_tick),
    .reload  (bus.ghost_reload)
  );

  assign bus.ghost_state  = ghost_state;
  assign bus.reverse      = reverse;
  assign bus.fright_flash = fright_flash;
  assign bus.phase        = phase;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with 1 tick per second, a 6-tick
// fright window (flash in the last 2) and 3-tick release spacing.
module tb_ghost_mode_scheduler;
  import ghost_mode_scheduler_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int ticks_sent  = 0;
  int rev_cnt     = 0;
  int rel_n  [4]  = '{0, 0, 0, 0};
  int rel_at [4]  = '{-1, -1, -1, -1};
  int dur    [7]  = '{7, 20, 7, 20, 5, 20, 5};

  ghost_mode_scheduler_if #(.NUM_GHOSTS(4)) bus ();

  ghost_mode_scheduler #(
    .NUM_GHOSTS    (4),
    .TICKS_PER_SEC (1),
    .FRIGHT_TICKS  (6),
    .FLASH_TICKS   (2),
    .RELEASE_GAP   (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: count reverse pulses and record release pulses per ghost.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reverse) rev_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (bus.ghost_reload[k]) begin
          rel_n[k]++;
          rel_at[k] = ticks_sent;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic p);
    bus.tick         = t;
    bus.power_pellet = p;
    @(posedge clk);
    #1;
    bus.tick         = 1'b0;
    bus.power_pellet = 1'b0;
  endtask

  task automatic tk();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    ticks_sent++;
  endtask

  initial begin
    int exp_m;
    bus.game_state   = GS_PLAY;
    bus.tick         = 1'b0;
    bus.power_pellet = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode",   int'(bus.ghost_state), int'(SCATTER));
    chk("rst_phase",  int'(bus.phase), 0);
    chk("rst_reload", int'(bus.ghost_reload), 0);
    chk("rst_rev",    int'(bus.reverse), 0);
    chk("rst_flash",  int'(bus.fright_flash), 0);
    rst_n = 1'b1;

    // First PLAY cycle releases ghost 0.
    cyc(1'b0, 1'b0);
    chk("first_reload", int'(bus.ghost_reload), 1);
    chk("first_mode",   int'(bus.ghost_state), int'(SCATTER));

    // Whole schedule: 7,20,7,20,5,20,5 ticks.
    for (int p = 0; p < 7; p++) begin
      repeat (dur[p] - 1) tk();
      exp_m = (p % 2 == 1) ? int'(CHASE) : int'(SCATTER);
      chk($sformatf("ph%0d_hold", p), int'(bus.phase), p);
      chk($sformatf("ph%0d_mode", p), int'(bus.ghost_state), exp_m);
      tk();
      exp_m = ((p + 1) % 2 == 1) ? int'(CHASE) : int'(SCATTER);
      chk($sformatf("ph%0d_next", p), int'(bus.phase), p + 1);
      chk($sformatf("ph%0d_nmode", p), int'(bus.ghost_state), exp_m);
      chk($sformatf("ph%0d_rev", p), rev_cnt, p + 1);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rel%0d_tick", k), rel_at[k], 3 * k);
      chk($sformatf("rel%0d_count", k), rel_n[k], 1);
    end
    repeat (100) tk();
    chk("ph7_stay",  int'(bus.phase), 7);
    chk("ph7_mode",  int'(bus.ghost_state), int'(CHASE));
    chk("ph7_rev",   rev_cnt, 7);

    // GS_RELOAD clears; re-entering PLAY re-releases ghost 0 at once.
    bus.game_state = GS_RELOAD;
    cyc(1'b0, 1'b0);
    chk("reload_phase", int'(bus.phase), 0);
    chk("reload_mode",  int'(bus.ghost_state), int'(SCATTER));
    bus.game_state = GS_PLAY;
    cyc(1'b0, 1'b0);
    chk("replay_rel0", int'(bus.ghost_reload), 1);
    repeat (5) tk();
    chk("replay_rel1", rel_n[1], 2);
    chk("replay_rel2", rel_n[2], 1);
    bus.game_state = GS_RELOAD;
    cyc(1'b0, 1'b0);
    chk("reload5_pulse", int'(bus.ghost_reload), 0);
    bus.game_state = GS_PLAY;
    cyc(1'b0, 1'b0);
    chk("reload5_rel0", int'(bus.ghost_reload), 1);

    // Pellet at phase 1, tick 10.
    repeat (7) tk();
    chk("p1_phase", int'(bus.phase), 1);
    chk("p1_rev",   rev_cnt, 8);
    repeat (10) tk();
    cyc(1'b0, 1'b1);
    chk("fr_mode",  int'(bus.ghost_state), int'(FRIGHTENED));
    chk("fr_phase", int'(bus.phase), 1);
    chk("fr_flash0", int'(bus.fright_flash), 0);
    cyc(1'b0, 1'b0);
    chk("fr_rev", rev_cnt, 9);
    repeat (3) tk();
    chk("fr_cnt3_flash", int'(bus.fright_flash), 0);
    tk();
    chk("fr_cnt2_flash", int'(bus.fright_flash), 1);
    tk();
    chk("fr_cnt1_mode", int'(bus.ghost_state), int'(FRIGHTENED));

    // Pellet coincident with the expiry tick: refreshed, no reverse.
    cyc(1'b1, 1'b1);
    chk("refresh_mode",  int'(bus.ghost_state), int'(FRIGHTENED));
    chk("refresh_flash", int'(bus.fright_flash), 0);
    cyc(1'b0, 1'b0);
    chk("refresh_rev", rev_cnt, 9);
    repeat (2) tk();

    // Pause mid-fright for 50 ticks (one with a pellet).
    bus.game_state = GS_PAUSE;
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 50; i++) cyc(1'b1, (i == 20));
    chk("pause_mode",  int'(bus.ghost_state), int'(FRIGHTENED));
    chk("pause_phase", int'(bus.phase), 1);
    chk("pause_flash", int'(bus.fright_flash), 0);
    chk("pause_rev",   rev_cnt, 9);
    bus.game_state = GS_PLAY;
    cyc(1'b0, 1'b0);
    tk();
    chk("resume_cnt3_flash", int'(bus.fright_flash), 0);
    tk();
    chk("resume_cnt2_flash", int'(bus.fright_flash), 1);
    tk();
    chk("resume_cnt1_mode", int'(bus.ghost_state), int'(FRIGHTENED));
    tk();
    chk("fr_exit_mode",  int'(bus.ghost_state), int'(CHASE));
    chk("fr_exit_flash", int'(bus.fright_flash), 0);
    chk("fr_exit_rev",   rev_cnt, 9);

    // Remaining 10 chase ticks of phase 1.
    repeat (9) tk();
    chk("p1_rest_hold", int'(bus.phase), 1);
    tk();
    chk("p2_phase", int'(bus.phase), 2);
    chk("p2_mode",  int'(bus.ghost_state), int'(SCATTER));
    chk("p2_rev",   rev_cnt, 10);

    // Leaving play from FRIGHT clears within one cycle.
    cyc(1'b0, 1'b1);
    chk("exit_fr_mode", int'(bus.ghost_state), int'(FRIGHTENED));
    bus.game_state = GS_GAMEOVER;
    cyc(1'b0, 1'b0);
    chk("gameover_mode",  int'(bus.ghost_state), int'(SCATTER));
    chk("gameover_phase", int'(bus.phase), 0);
    chk("gameover_rev",   int'(bus.reverse), 0);
    chk("gameover_flash", int'(bus.fright_flash), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
